// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// gemm_pkg : shared state encoding and default sizing for the GEMM sequencer
// Rev 1.0
// ============================================================================
package gemm_pkg;

  localparam int GEMM_PRM_WORDS = 32;  // 4 banks x 8 beats
  localparam int GEMM_DST_WORDS = 16;
  localparam int GEMM_KLEN      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } gemm_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_kwin.sv
`default_nettype none
// ============================================================================
// gemm_kwin : compute-window engine (depth-1 request flag, k_init/k_fin/s_fin)
// Rev 1.0
// ============================================================================
module gemm_kwin
  import gemm_pkg::*;
#(
  parameter int LOOP1_W = 8,
  parameter int KLEN    = GEMM_KLEN
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               req_in,
  input  logic               out_busy,
  input  logic [LOOP1_W-1:0] loop1_cnt,
  output logic               win_start,
  output logic               win_active,
  output logic               win_last,
  output logic               pending,
  output logic               k_init,
  output logic               k_fin,
  output logic               s_fin
);

  logic pending_q, pending_d;
  logic active_q, active_d;

  // The s_fin cycle may hand straight over to the next window.
  always_comb begin
    win_last  = active_q && (loop1_cnt == LOOP1_W'(KLEN));
    win_start = (pending_q || req_in) && (!active_q || win_last) && !out_busy && !clr;
    pending_d = pending_q || req_in;
    active_d  = active_q && !win_last;
    if (win_start) begin
      pending_d = 1'b0;
      active_d  = 1'b1;
    end
    if (clr) begin
      pending_d = 1'b0;
      active_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign win_active = active_q;
  assign pending    = pending_q;
  assign k_init     = active_q && (loop1_cnt == '0);
  assign k_fin      = active_q && (loop1_cnt == LOOP1_W'(KLEN - 1));
  assign s_fin      = win_last;

endmodule
`default_nettype wire

// File: rtl/gemm_seq.sv
`default_nettype none
// ============================================================================
// gemm_seq : per-job sequencer (weight load, batch windows, result drain)
// Rev 1.0
// ============================================================================
module gemm_seq
  import gemm_pkg::*;
#(
  parameter int BATCH_W   = 8,
  parameter int PRM_WORDS = GEMM_PRM_WORDS,
  parameter int DST_WORDS = GEMM_DST_WORDS,
  parameter int KLEN      = GEMM_KLEN
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load_prm,
  input  logic [BATCH_W-1:0] cmd_nbatch,
  input  logic               abort,
  output logic               matw,
  output logic               run,
  input  logic               src_beat,
  input  logic               s_init,
  input  logic               out_busy,
  output logic               k_init,
  output logic               k_fin,
  output logic               s_fin,
  input  logic               dst_beat,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int PRM_CW  = $clog2(PRM_WORDS);
  localparam int WIN_CW  = $clog2(KLEN + 1);
  localparam int LOOP1_W = (PRM_CW > WIN_CW) ? PRM_CW : WIN_CW;
  localparam int DCNT_W  = BATCH_W + $clog2(DST_WORDS);

  gemm_seq_state_t    state_q, state_d;
  logic [BATCH_W-1:0] nbatch_q, nbatch_d;
  logic [BATCH_W-1:0] sinit_cnt_q, sinit_cnt_d;
  logic [BATCH_W-1:0] kinit_cnt_q, kinit_cnt_d;
  logic [BATCH_W-1:0] sfin_cnt_q, sfin_cnt_d;
  logic [DCNT_W-1:0]  dst_cnt_q, dst_cnt_d;
  logic [LOOP1_W-1:0] loop1_q, loop1_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               abort_hit;
  logic               sinit_acc;
  logic               clr_cnt;
  logic               dst_ok;
  logic [DCNT_W-1:0]  dst_budget;
  logic [DCNT_W-1:0]  dst_target;
  logic               win_start, win_active, win_last, pending;

  assign abort_hit  = abort && (state_q != ST_IDLE);
  assign sinit_acc  = (state_q == ST_RUN) && s_init && !pending &&
                      (sinit_cnt_q != nbatch_q) && !abort_hit;
  // Beats may only drain against streams that have been started, this cycle included.
  assign dst_budget = (DCNT_W'(sfin_cnt_q) + DCNT_W'(s_fin)) * DCNT_W'(DST_WORDS);
  assign dst_target = DCNT_W'(nbatch_q) * DCNT_W'(DST_WORDS);
  assign dst_ok     = dst_beat && (dst_cnt_q < dst_budget);

  gemm_kwin #(
    .LOOP1_W (LOOP1_W),
    .KLEN    (KLEN)
  ) u_kwin (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (abort_hit),
    .req_in     (sinit_acc),
    .out_busy   (out_busy),
    .loop1_cnt  (loop1_q),
    .win_start  (win_start),
    .win_active (win_active),
    .win_last   (win_last),
    .pending    (pending),
    .k_init     (k_init),
    .k_fin      (k_fin),
    .s_fin      (s_fin)
  );

  always_comb begin
    state_d     = state_q;
    nbatch_d    = nbatch_q;
    sinit_cnt_d = sinit_cnt_q;
    kinit_cnt_d = kinit_cnt_q;
    sfin_cnt_d  = sfin_cnt_q;
    dst_cnt_d   = dst_cnt_q;
    loop1_d     = loop1_q;
    done_d      = done_q;
    err_d       = err_q;
    clr_cnt     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_cnt = 1'b1;
        if (cmd_valid && !abort) begin
          done_d   = 1'b0;
          nbatch_d = cmd_nbatch;
          if (cmd_load_prm) begin
            state_d = ST_PRM;
          end else if (cmd_nbatch != '0) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PRM: begin
        // loop1 counts parameter beats here; no window can be active yet.
        if (src_beat) begin
          if (loop1_q == LOOP1_W'(PRM_WORDS - 1)) begin
            loop1_d = '0;
            if (nbatch_q == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            loop1_d = loop1_q + 1'b1;
          end
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (win_start) begin
          loop1_d = '0;
        end else if (win_active && !win_last) begin
          loop1_d = loop1_q + 1'b1;
        end
        if (s_init && !sinit_acc) err_d = 1'b1;
        if (sinit_acc) sinit_cnt_d = sinit_cnt_q + 1'b1;
        if (src_beat && (sinit_cnt_q == nbatch_q)) err_d = 1'b1;
        if (k_init) begin
          kinit_cnt_d = kinit_cnt_q + 1'b1;
          if ((state_q == ST_RUN) && (kinit_cnt_q == nbatch_q - 1'b1)) state_d = ST_DRAIN;
        end
        if (s_fin) sfin_cnt_d = sfin_cnt_q + 1'b1;
        if (dst_ok) begin
          dst_cnt_d = dst_cnt_q + 1'b1;
          if ((state_q == ST_DRAIN) && ((dst_cnt_q + 1'b1) == dst_target)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            clr_cnt = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dst_beat && !dst_ok) err_d = 1'b1;

    if (abort_hit) begin
      state_d = ST_IDLE;
      done_d  = done_q;
      err_d   = err_q;
      clr_cnt = 1'b1;
    end

    if (clr_cnt) begin
      sinit_cnt_d = '0;
      kinit_cnt_d = '0;
      sfin_cnt_d  = '0;
      dst_cnt_d   = '0;
      loop1_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      nbatch_q    <= '0;
      sinit_cnt_q <= '0;
      kinit_cnt_q <= '0;
      sfin_cnt_q  <= '0;
      dst_cnt_q   <= '0;
      loop1_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nbatch_q    <= nbatch_d;
      sinit_cnt_q <= sinit_cnt_d;
      kinit_cnt_q <= kinit_cnt_d;
      sfin_cnt_q  <= sfin_cnt_d;
      dst_cnt_q   <= dst_cnt_d;
      loop1_q     <= loop1_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign matw      = (state_q == ST_PRM);
  assign run       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_seq.sv
`default_nettype none
// ============================================================================
// tb_gemm_seq : directed self-checking bench for gemm_seq (KLEN=8, 32/16 beats)
// Rev 1.0
// ============================================================================
module tb_gemm_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_load_prm, abort, src_beat, s_init, out_busy, dst_beat;
  logic [7:0] cmd_nbatch;
  logic       cmd_ready, matw, run, k_init, k_fin, s_fin, busy, done, err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] ki_m, kf_m, sf_m, er_m;
  int          matw_cnt;
  logic        run_seen;

  gemm_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load_prm (cmd_load_prm),
    .cmd_nbatch   (cmd_nbatch),
    .abort        (abort),
    .matw         (matw),
    .run          (run),
    .src_beat     (src_beat),
    .s_init       (s_init),
    .out_busy     (out_busy),
    .k_init       (k_init),
    .k_fin        (k_fin),
    .s_fin        (s_fin),
    .dst_beat     (dst_beat),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // {cmd_ready, matw, run, k_init, k_fin, s_fin, busy, done, err}
  function automatic logic [8:0] obs_vec();
    return {cmd_ready, matw, run, k_init, k_fin, s_fin, busy, done, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic prm, input logic [7:0] nb);
    cmd_valid = 1'b1; cmd_load_prm = prm; cmd_nbatch = nb;
    tick();
    cmd_valid = 1'b0; cmd_load_prm = 1'b0; cmd_nbatch = 8'd0;
  endtask

  task automatic dst_burst(input int n);
    for (int i = 0; i < n; i++) begin
      dst_beat = 1'b1;
      tick();
    end
    dst_beat = 1'b0;
  endtask

  // Cycle 0 is the cycle right after the command was accepted.
  task automatic scan(input int ncyc, input logic [63:0] sinit_m, input logic [63:0] obusy_m);
    ki_m = '0; kf_m = '0; sf_m = '0; er_m = '0;
    for (int c = 0; c < ncyc; c++) begin
      s_init   = sinit_m[c];
      src_beat = sinit_m[c];
      out_busy = obusy_m[c];
      ki_m[c]  = k_init;
      kf_m[c]  = k_fin;
      sf_m[c]  = s_fin;
      er_m[c]  = err;
      tick();
    end
    s_init = 1'b0; src_beat = 1'b0; out_busy = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_load_prm = 1'b0; cmd_nbatch = 8'd0;
    abort = 1'b0; src_beat = 1'b0; s_init = 1'b0; out_busy = 1'b0; dst_beat = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("reset_outputs", obs_vec(), 9'b100000000);

    // Weight load only
    send_cmd(1'b1, 8'd0);
    chk("prm_entry", obs_vec(), 9'b010000100);
    matw_cnt = 0; run_seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      src_beat = 1'b1;
      matw_cnt += int'(matw);
      run_seen |= run;
      tick();
    end
    src_beat = 1'b0;
    chk("prm_matw_beats", matw_cnt, 32);
    chk("prm_run_never", run_seen, 1'b0);
    chk("prm_done", obs_vec(), 9'b100000010);

    // Single batch
    send_cmd(1'b0, 8'd1);
    chk("b1_entry", obs_vec(), 9'b001000100);
    scan(12, 64'h2, 64'h0);
    chk("b1_k_init", ki_m, 64'h4);
    chk("b1_k_fin", kf_m, 64'h200);
    chk("b1_s_fin", sf_m, 64'h400);
    dst_burst(15);
    chk("b1_not_done_15", obs_vec(), 9'b001000100);
    dst_burst(1);
    chk("b1_done", obs_vec(), 9'b100000010);

    // Three batches, overlapping s_init, out_busy high cycles 12..20
    send_cmd(1'b0, 8'd3);
    scan(34, (64'h1 << 1) | (64'h1 << 6) | (64'h1 << 11), 64'h1FF << 12);
    chk("b3_k_init", ki_m, (64'h1 << 2) | (64'h1 << 11) | (64'h1 << 22));
    chk("b3_k_fin", kf_m, (64'h1 << 9) | (64'h1 << 18) | (64'h1 << 29));
    chk("b3_s_fin", sf_m, (64'h1 << 10) | (64'h1 << 19) | (64'h1 << 30));
    chk("b3_err_clean", er_m, 64'h0);
    dst_burst(47);
    chk("b3_not_done_47", obs_vec(), 9'b001000100);
    dst_burst(1);
    chk("b3_done", obs_vec(), 9'b100000010);

    // Abort during drain after 7 of 16 beats
    send_cmd(1'b0, 8'd1);
    scan(12, 64'h2, 64'h0);
    dst_burst(7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", obs_vec(), 9'b100000000);

    // Zero-batch command without weight load
    send_cmd(1'b0, 8'd0);
    chk("nb0_done", obs_vec(), 9'b100000010);

    // Abort together with cmd_valid in IDLE: command not taken, done kept
    cmd_valid = 1'b1; cmd_nbatch = 8'd1; abort = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_nbatch = 8'd0; abort = 1'b0;
    chk("abort_cmd_collide", obs_vec(), 9'b100000010);

    // Fresh job completes normally after abort
    send_cmd(1'b0, 8'd1);
    chk("fresh_entry", obs_vec(), 9'b001000100);
    scan(12, 64'h2, 64'h0);
    chk("fresh_k_init", ki_m, 64'h4);
    dst_burst(16);
    chk("fresh_done", obs_vec(), 9'b100000010);

    // Pending overflow: s_init at 1, 3, 5 -> third dropped with err
    send_cmd(1'b0, 8'd3);
    scan(26, (64'h1 << 1) | (64'h1 << 3) | (64'h1 << 5), 64'h0);
    chk("ovf_k_init", ki_m, (64'h1 << 2) | (64'h1 << 11));
    chk("ovf_err_timing", er_m, 64'h3FFFFC0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ovf_abort_err_kept", obs_vec(), 9'b100000001);

    // Asynchronous reset mid-window
    send_cmd(1'b0, 8'd1);
    scan(5, 64'h2, 64'h0);
    reset_n = 1'b0;
    #2;
    chk("async_reset", obs_vec(), 9'b100000000);
    tick(); tick();
    reset_n = 1'b1;
    scan(14, 64'h0, 64'h0);
    chk("post_reset_k_fin", kf_m, 64'h0);
    chk("post_reset_s_fin", sf_m, 64'h0);
    chk("post_reset_idle", obs_vec(), 9'b100000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_seq.md
# gemm_seq

Top-level sequencer for the GEMM core. Accepts one command per job: optional weight load, then N source batches. Drives `matw`/`run` into the batch controller, issues `k_init`/`k_fin` compute windows to the core and output unit, issues `s_fin` to start each result stream, and counts drained result beats to signal job completion. Sits between the register/DMA command interface and the batch and output controllers.

## Interface
- `BATCH_W`, 8: width of the batch-count field.
- `PRM_WORDS`, 32: parameter beats per weight load (4 banks x 8).
- `DST_WORDS`, 16: result beats per batch.
- `KLEN`, 8: compute-window length in cycles; legal range is 2..255.

- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_load_prm`  in  1  run the weight-load phase first.
- `cmd_nbatch`  in  BATCH_W  number of batches; 0 is legal.
- `abort`  in  1  single-cycle pulse; cancels the job.
- `matw`  out  1  weight-load phase active.
- `run`  out  1  batch phase active.
- `src_beat`  in  1  accepted source/parameter beat (valid & ready).
- `s_init`  in  1  last source beat of a batch accepted.
- `out_busy`  in  1  output unit cannot accept a new window.
- `k_init`  out  1  compute-window start pulse.
- `k_fin`  out  1  compute-window end pulse.
- `s_fin`  out  1  result-stream start pulse.
- `dst_beat`  in  1  accepted result beat.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  job completed; level, cleared on next command accept.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, PRM, RUN, DRAIN.
- IDLE → PRM on `cmd_valid` with `cmd_load_prm`=1.
- IDLE → RUN on `cmd_valid` with `cmd_load_prm`=0 and `cmd_nbatch`≠0.
- `cmd_nbatch`=0 with no weight load: `done` rises the next cycle; no `run` assertion.
- PRM: `matw`=1. Count `src_beat`. On beat `PRM_WORDS`, go to RUN, or to IDLE with `done` if nbatch=0.
- RUN: `run`=1. Each `s_init` queues one compute request in a depth-1 pending flag.
- Compute engine: when a request is pending, no window is active and `out_busy`=0, pulse `k_init`, then pulse `k_fin` after KLEN cycles, then pulse `s_fin`. Consuming the request clears pending.
- `s_init` is legal while a window is active (the next batch overlaps compute).
- `s_init` while pending is already set: set `err`, drop that request.
- After the nbatch-th `s_init` is accepted, further `s_init` or `src_beat`: set `err`, ignore.
- RUN → DRAIN when the nbatch-th `k_init` has issued.
- DRAIN: `run` stays 1. Exit to IDLE with `done`=1 when the total `dst_beat` count = nbatch × DST_WORDS.
- Any `dst_beat` beyond that total, or while no `s_fin` is outstanding: set `err`.
- `abort` in any non-IDLE state: next cycle is IDLE. `matw`, `run`, and an in-flight window all drop. `done` stays 0; `err` is unchanged; counters clear.
- `abort` in IDLE is ignored.
- `abort` and `cmd_valid` in the same cycle: abort wins; the command is not accepted.
- Counter widths: batch counters are BATCH_W bits; the drained-beat counter is BATCH_W+log2(DST_WORDS) bits. No counter wraps inside a legal job.

## Timing
- Reset values: `cmd_ready`=1. All other outputs are 0. State is IDLE; counters and pending flag are 0.
- Command accepted at edge t: `matw` or `run` is high from t+1. `cmd_ready` is low from t+1. `done` is low from t+1.
- `k_init` is registered: earliest one cycle after `s_init` (pending set at edge t, `k_init` high in cycle t+1).
- `out_busy` high delays `k_init` cycle-for-cycle.
- `k_init` in cycle c → `k_fin` in cycle c+KLEN-1 → `s_fin` in cycle c+KLEN.
- Next `k_init` earliest in cycle c+KLEN+1.
- Last PRM beat at edge t: `matw` low and `run` high in cycle t+1; no gap cycle.
- Final `dst_beat` at edge t: `run` low, `busy` low, `done` high, `cmd_ready` high, all in cycle t+1.
- `err` rises one cycle after the offending beat.

## Structure
- `gemm_pkg` holds:
  - the `gemm_seq_state_t` enum;
  - the `PRM_WORDS` and `DST_WORDS` defaults;
  - the `KLEN` default.
- The PRM beat counter and per-window cycle counter reuse the existing `loop1` counter.
- The compute engine (pending flag, window counter, `k_init`/`k_fin`/`s_fin`) is the natural sub-module: `gemm_kwin`.

## Test plan
- Weight load: load_prm=1, nbatch=0, 32 `src_beat` → `matw` high for exactly those 32 beats; `done`=1 the cycle after beat 32; `run` never high.
- Single batch: nbatch=1, `s_init` at cycle 10, KLEN=8 → `k_init`@11, `k_fin`@18, `s_fin`@19. After 16 `dst_beat`, `done`=1 the following cycle.
- Overlap and back-pressure: nbatch=3, `s_init` every 5 cycles, `out_busy` high for cycles 12–20 → each `k_init` follows the previous `s_fin` and `out_busy` falling. `err`=0. `done` after 48 beats.
- Pending overflow: two `s_init` while the window is active and pending is set → `err`=1; only 2 of 3 windows issue.
- Abort: `abort` during DRAIN with 7 of 16 beats drained → IDLE next cycle; `run`=0, `done`=0, `cmd_ready`=1. A fresh job then completes normally.
- Reset: `reset_n` low mid-window → all outputs at reset values immediately (asynchronous); no `k_fin` after release.
